// File: rtl/rect_filler.sv
// Solid-colour rectangle filler: clips a rectangle to the frame and writes it as
// 8-pixel DDR2 requests (one address entry plus two 128-bit data beats each).
module rect_filler #(
    parameter int X_BITS  = 10,
    parameter int Y_BITS  = 10,
    parameter int FRAME_W = 800,
    parameter int FRAME_H = 600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    output logic              ready,
    input  logic [X_BITS-1:0] x0,
    input  logic [X_BITS-1:0] x1,
    input  logic [Y_BITS-1:0] y0,
    input  logic [Y_BITS-1:0] y1,
    input  logic [23:0]       color,
    input  logic [31:0]       frame_base,
    input  logic              af_full,
    input  logic              wdf_full,
    output logic [30:0]       af_addr_din,
    output logic              af_wr_en,
    output logic [127:0]      wdf_din,
    output logic              wdf_wr_en,
    output logic [15:0]       wdf_mask_din,
    output logic              done
);

    localparam int XW1   = X_BITS + 1;
    localparam int OFF_W = Y_BITS + X_BITS - 1;
    localparam logic [X_BITS-1:0] X_MAX = X_BITS'(FRAME_W - 1);
    localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(FRAME_H - 1);

    typedef enum logic [2:0] {IDLE, SETUP, ADDR, DATA2, DONE} state_t;

    state_t            state;
    logic [X_BITS-1:0] x0_r;
    logic [X_BITS-1:0] x1_r;   // holds the clipped right bound once SETUP has run
    logic [Y_BITS-1:0] y1_r;   // holds the clipped bottom bound once SETUP has run
    logic [X_BITS-1:0] bx;
    logic [Y_BITS-1:0] y;
    logic [23:0]       color_r;
    logic [31:0]       base_r;

    logic [X_BITS-1:0] x1c;
    logic [Y_BITS-1:0] y1c;
    logic [X_BITS-1:0] bx_first;
    logic [X_BITS-1:0] bx_last;
    logic              go;
    logic              active;
    logic [15:0]       mask;
    logic [OFF_W-1:0]  off;

    assign x1c      = (x1_r > X_MAX) ? X_MAX : x1_r;
    assign y1c      = (y1_r > Y_MAX) ? Y_MAX : y1_r;
    assign bx_first = {x0_r[X_BITS-1:3], 3'b000};
    assign bx_last  = {x1_r[X_BITS-1:3], 3'b000};
    assign go       = !af_full && !wdf_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            x0_r    <= '0;
            x1_r    <= '0;
            y1_r    <= '0;
            bx      <= '0;
            y       <= '0;
            color_r <= '0;
            base_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        x0_r    <= x0;
                        x1_r    <= x1;
                        y1_r    <= y1;
                        y       <= y0;
                        color_r <= color;
                        base_r  <= frame_base;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    x1_r <= x1c;
                    y1_r <= y1c;
                    bx   <= bx_first;
                    if (x0_r > x1c || y > y1c)
                        state <= DONE;
                    else
                        state <= ADDR;
                end
                ADDR: begin
                    if (go)
                        state <= DATA2;
                end
                DATA2: begin
                    if (go) begin
                        if (bx == bx_last) begin
                            if (y == y1_r) begin
                                state <= DONE;
                            end else begin
                                bx    <= bx_first;
                                y     <= y + Y_BITS'(1);
                                state <= ADDR;
                            end
                        end else begin
                            bx    <= bx + X_BITS'(8);
                            state <= ADDR;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes depend on the FIFO full flags in the same cycle; rst gating keeps
    // the bus quiet for the whole reset cycle, not just after the edge.
    assign active = rst && (state == ADDR || state == DATA2);
    assign ready  = rst && (state == IDLE);
    assign done   = rst && (state == DONE);

    assign af_wr_en  = rst && (state == ADDR) && go;
    assign wdf_wr_en = active && go;

    always_comb begin
        mask = '1;
        for (int unsigned k = 0; k < 4; k++) begin
            logic [X_BITS:0] col;
            col = {1'b0, bx} + XW1'(k) + ((state == DATA2) ? XW1'(4) : XW1'(0));
            if (col >= {1'b0, x0_r} && col <= {1'b0, x1_r})
                mask[4*k +: 4] = 4'h0;
        end
    end

    assign wdf_mask_din = active ? mask : 16'hFFFF;
    assign wdf_din      = {4{8'h00, color_r}};

    assign off         = {y, bx[X_BITS-1:3], 2'b00};
    assign af_addr_din = 31'(base_r >> 3) + 31'(off);

endmodule

// File: tb/tb_rect_filler.sv
// Randomised and directed bench for rect_filler against a behavioural
// rectangle-to-request model.
module tb_rect_filler;

    localparam int XB = 10;
    localparam int YB = 10;
    localparam int FW = 800;
    localparam int FH = 600;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          ready;
    logic [XB-1:0] x0, x1;
    logic [YB-1:0] y0, y1;
    logic [23:0]   color;
    logic [31:0]   frame_base;
    logic          af_full, wdf_full;
    logic [30:0]   af_addr_din;
    logic          af_wr_en;
    logic [127:0]  wdf_din;
    logic          wdf_wr_en;
    logic [15:0]   wdf_mask_din;
    logic          done;

    always #5 clk = ~clk;

    rect_filler #(.X_BITS(XB), .Y_BITS(YB), .FRAME_W(FW), .FRAME_H(FH)) dut (
        .clk(clk), .rst(rst), .valid(valid), .ready(ready),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color), .frame_base(frame_base),
        .af_full(af_full), .wdf_full(wdf_full),
        .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
        .wdf_din(wdf_din), .wdf_wr_en(wdf_wr_en), .wdf_mask_din(wdf_mask_din),
        .done(done)
    );

    typedef struct {
        logic [30:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
        bit           first;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    done_cnt = 0;
    int    exp_done = 0;
    bit    bp_en = 0;

    function automatic void check(input bit ok, input string name,
                                  input logic [159:0] got, input logic [159:0] want);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endfunction

    // Every pixel of the clipped rectangle, grouped into 8-pixel aligned blocks.
    task automatic build_model(input int ax0, input int ax1, input int ay0, input int ay1,
                               input logic [23:0] c, input logic [31:0] base);
        int    cx1, cy1;
        longint a;
        beat_t e;
        cx1 = (ax1 > FW - 1) ? FW - 1 : ax1;
        cy1 = (ay1 > FH - 1) ? FH - 1 : ay1;
        if (ax0 > cx1 || ay0 > cy1) return;
        for (int yy = ay0; yy <= cy1; yy++) begin
            for (int b = (ax0 / 8) * 8; b <= cx1; b += 8) begin
                a = longint'(base >> 3) + longint'(yy) * (1 << (XB - 1)) + longint'(b / 8) * 4;
                for (int beat = 0; beat < 2; beat++) begin
                    e.addr  = a[30:0];
                    e.data  = {4{8'h00, c}};
                    e.first = (beat == 0);
                    e.mask  = '1;
                    for (int k = 0; k < 4; k++) begin
                        int col;
                        col = b + 4 * beat + k;
                        if (col >= ax0 && col <= cx1) e.mask[4*k +: 4] = 4'h0;
                    end
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Compare process: every pushed beat is matched against the model queue.
    logic        prev_stall = 1'b0;
    logic [30:0] prev_addr;
    logic [15:0] prev_mask;
    logic [127:0] prev_data;
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check(!ready && !af_wr_en && !wdf_wr_en && !done && wdf_mask_din == 16'hFFFF,
                      "reset_outputs", {ready, af_wr_en, wdf_wr_en, done, wdf_mask_din},
                      {4'b0000, 16'hFFFF});
            end else begin
                if (af_wr_en || wdf_wr_en) begin
                    check(!(af_wr_en && !wdf_wr_en), "af_without_wdf", {af_wr_en, wdf_wr_en}, 2'b11);
                    check(!af_full && !wdf_full, "push_while_full", {af_full, wdf_full}, 2'b00);
                end
                if (wdf_wr_en) begin
                    check(exp_q.size() > 0, "unexpected_push", af_addr_din, 0);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check(af_addr_din == e.addr, "beat_addr", af_addr_din, e.addr);
                        check(wdf_din == e.data, "beat_data", wdf_din, e.data);
                        check(wdf_mask_din == e.mask, "beat_mask", wdf_mask_din, e.mask);
                        check(af_wr_en == e.first, "beat_af_strobe", af_wr_en, e.first);
                    end
                end
                if (done) begin
                    done_cnt++;
                    check(exp_q.size() == 0, "done_with_pending", exp_q.size(), 0);
                end
                if (prev_stall) begin
                    check(af_addr_din == prev_addr && wdf_mask_din == prev_mask && wdf_din == prev_data,
                          "stall_stable", {af_addr_din, wdf_mask_din}, {prev_addr, prev_mask});
                end
            end
            prev_stall = rst && (af_full || wdf_full) && wdf_mask_din != 16'hFFFF;
            prev_addr  = af_addr_din;
            prev_mask  = wdf_mask_din;
            prev_data  = wdf_din;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_en) begin
            af_full  = ($urandom_range(0, 3) == 0);
            wdf_full = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic issue(input int ax0, input int ax1, input int ay0, input int ay1,
                         input logic [23:0] c, input logic [31:0] base);
        build_model(ax0, ax1, ay0, ay1, c, base);
        exp_done++;
        x0 = XB'(ax0); x1 = XB'(ax1); y0 = YB'(ay0); y1 = YB'(ay1);
        color = c; frame_base = base;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        x0 = XB'($urandom); x1 = XB'($urandom); y0 = YB'($urandom); y1 = YB'($urandom);
        color = 24'($urandom); frame_base = $urandom;
    endtask

    task automatic wait_done(input int budget, output int lat);
        bit found;
        found = 0;
        lat = 0;
        while (!found && lat < budget) begin
            @(negedge clk);
            lat++;
            if (done) found = 1;
            else tick();
        end
        check(found, "done_timeout", lat, budget);
        if (found) begin
            @(negedge clk);
            check(ready, "ready_after_done", ready, 1'b1);
        end
        tick();
    endtask

    initial begin
        int lat;
        int n_af;
        int rx0, rx1, ry0, ry1, t;
        rst = 1'b0; valid = 1'b0; af_full = 1'b0; wdf_full = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0; frame_base = '0;
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        check(ready, "ready_after_reset", ready, 1'b1);
        tick();

        // Edge masks; the model is pinned with hand-worked values first.
        issue(3, 10, 5, 6, 24'h123456, 32'h0100_0000);
        check(exp_q.size() == 8, "model_edge_size", exp_q.size(), 8);
        check(exp_q[0].addr == 31'h200A00, "model_edge_addr0", exp_q[0].addr, 31'h200A00);
        check(exp_q[0].mask == 16'h0FFF, "model_edge_mask0", exp_q[0].mask, 16'h0FFF);
        check(exp_q[1].mask == 16'h0000, "model_edge_mask1", exp_q[1].mask, 16'h0000);
        check(exp_q[2].addr == 31'h200A04, "model_edge_addr2", exp_q[2].addr, 31'h200A04);
        check(exp_q[2].mask == 16'hF000, "model_edge_mask2", exp_q[2].mask, 16'hF000);
        check(exp_q[3].mask == 16'hFFFF, "model_edge_mask3", exp_q[3].mask, 16'hFFFF);
        wait_done(100, lat);
        check(lat == 10, "edge_done_latency", lat, 10);

        // Full-width rows at the bottom of the frame, with y1 past the frame edge.
        issue(0, 799, 597, 650, 24'hA5C3E1, 32'h0200_0000);
        check(exp_q.size() == 600, "model_full_size", exp_q.size(), 600);
        check(exp_q[599].addr == 31'h44AF8C, "model_full_last_addr", exp_q[599].addr, 31'h44AF8C);
        wait_done(1000, lat);
        check(lat == 602, "full_done_latency", lat, 602);

        issue(784, 1000, 700, 700, 24'h00FF00, 32'h0040_0000);
        wait_done(20, lat);
        check(lat == 2, "clip_empty_latency", lat, 2);

        issue(784, 1000, 10, 10, 24'h00FF00, 32'h0040_0000);
        wait_done(20, lat);
        check(lat == 6, "clip_row_latency", lat, 6);

        issue(20, 5, 3, 4, 24'hFF0000, 32'h0040_0000);
        wait_done(20, lat);
        check(lat == 2, "inverted_x_latency", lat, 2);

        // Directed backpressure: af_full across ADDR, wdf_full across DATA2.
        issue(0, 15, 0, 0, 24'h0F0F0F, 32'h0080_0000);
        af_full = 1'b1;
        repeat (6) tick();
        af_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (af_wr_en) break;
            tick();
        end
        tick();
        wdf_full = 1'b1;
        repeat (3) tick();
        wdf_full = 1'b0;
        wait_done(100, lat);

        // A second command while busy must be ignored.
        issue(0, 23, 100, 101, 24'h777777, 32'h00C0_0000);
        tick();
        x0 = 10'd400; x1 = 10'd500; y0 = 10'd1; y1 = 10'd2; valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_done(100, lat);

        // Reset during DATA2 of the third request.
        issue(8, 31, 50, 51, 24'h314159, 32'h0100_0000);
        n_af = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (af_wr_en) n_af++;
            if (n_af == 3) break;
            tick();
        end
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_done--;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check(ready, "ready_after_midreset", ready, 1'b1);
        repeat (3) tick();
        issue(16, 16, 200, 200, 24'h2468AC, 32'h0100_0000);
        wait_done(20, lat);
        check(lat == 4, "post_reset_latency", lat, 4);

        // Random rectangles under random backpressure.
        bp_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rx0 = $urandom_range(0, 830);
            rx1 = rx0 + $urandom_range(0, 40);
            ry0 = $urandom_range(0, 605);
            ry1 = ry0 + $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) begin
                t = rx0; rx0 = rx1; rx1 = t;
            end
            issue(rx0, rx1, ry0, ry1, 24'($urandom), $urandom & 32'hFFC0_0000);
            wait_done(2000, lat);
        end
        bp_en = 1'b0;
        af_full = 1'b0;
        wdf_full = 1'b0;
        repeat (3) tick();
        check(done_cnt == exp_done, "done_count", done_cnt, exp_done);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rect_filler.md
Name: rect_filler

Overview:
- Parametrised successor to the full-frame filler: fills an arbitrary axis-aligned rectangle of a frame buffer with a solid colour.
- Issues 8-pixel DDR2 write requests: one address-FIFO entry plus two 128-bit write-data beats.
- Uses per-pixel byte masks at the rectangle's left and right edges, and clips the rectangle to the frame.
- Sits between the graphics command processor and the DDR2 request arbiter.

Parameters:
- X_BITS, 10, column coordinate width; line stride is 2^X_BITS pixels.
- Y_BITS, 10, row coordinate width.
- FRAME_W, 800, visible width in pixels; multiple of 8.
- FRAME_H, 600, visible height in pixels.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-low.
- valid  in  1  command valid.
- ready  out  1  block idle, can accept a command.
- x0, x1  in  X_BITS  inclusive column bounds.
- y0, y1  in  Y_BITS  inclusive row bounds.
- color  in  24  RGB fill colour.
- frame_base  in  32  byte address of the frame; low X_BITS+Y_BITS+2 bits are zero.
- af_full  in  1  DDR2 address FIFO full.
- wdf_full  in  1  DDR2 write-data FIFO full.
- af_addr_din  out  31  request address, 8-byte units.
- af_wr_en  out  1  address FIFO push.
- wdf_din  out  128  write data.
- wdf_wr_en  out  1  write-data FIFO push.
- wdf_mask_din  out  16  byte mask; 1 means byte not written.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (rst low at a clock edge):
  - State becomes IDLE and all counters clear.
  - While rst is low: ready=0, af_wr_en=0, wdf_wr_en=0, done=0, wdf_mask_din=16'hFFFF.
  - ready=1 in the first cycle after release.
- Reset mid-operation: requests stop immediately. If reset lands between the ADDR and DATA2 beats, an orphan beat may remain in the DDR FIFO; flushing it is the caller's responsibility.
- Accept: valid&&ready at edge T latches x0, x1, y0, y1, color and frame_base. Inputs are ignored outside accept.
- States: IDLE, SETUP, ADDR, DATA2, DONE.
- SETUP (one cycle):
  - Clip: x1c=min(x1,FRAME_W-1), y1c=min(y1,FRAME_H-1).
  - If x0>x1c or y0>y1c, go to DONE with no writes.
  - Otherwise set bx=x0&~7, y=y0 and go to ADDR. The first ADDR cycle is T+2.
- Push condition: go = !af_full && !wdf_full.
- ADDR:
  - af_wr_en = wdf_wr_en = go.
  - Data is beat 0, pixels bx..bx+3.
  - If go, go to DATA2; otherwise hold, with all outputs stable.
- DATA2:
  - af_wr_en=0, wdf_wr_en=go. Data is beat 1, pixels bx+4..bx+7.
  - If go:
    - If bx==(x1c&~7) and y==y1c, go to DONE.
    - Else if bx==(x1c&~7), set bx=x0&~7, y=y+1, go to ADDR.
    - Else set bx=bx+8, go to ADDR.
  - If not go, hold.
- DONE: done=1 and ready=0 for one cycle, then IDLE.
- Data and mask layout:
  - Pixel k of a beat (k=0..3) occupies wdf_din[32k+31:32k] = {8'h00, color}.
  - The mask bits for pixel k are [4k+3:4k]: 4'h0 if x0<=pixel column<=x1c, else 4'hF.
- Address:
  - af_addr_din = (frame_base>>3) + {y, bx[X_BITS-1:3], 2'b00}.
  - The sum is truncated to 31 bits and stays constant across both beats of a request.
- Strobes outside ADDR and DATA2 are 0; wdf_mask_din is 16'hFFFF there.
- af_wr_en is never asserted without wdf_wr_en in the same cycle.

Test Plan:
- Full frame: x0=0, x1=799, y0=0, y1=599, no backpressure.
  - Expect exactly 60000 af pushes and 120000 wdf pushes, all masks 16'h0000.
  - Last address = (base>>3)+{599,99,2'b00}. One done pulse; ready returns the cycle after.
- Edge masks: x0=3, x1=10, y0=5, y1=6, frame_base=32'h0100_0000.
  - Expect 4 requests; row-5 addresses are 31'h200A00 and 31'h200A04.
  - Block 0 masks: 16'h0FFF then 16'h0000.
  - Block 8 masks: 16'hF000 then 16'hFFFF.
- Backpressure: hold af_full=1 for 5 cycles while in ADDR, and wdf_full=1 for 3 cycles while in DATA2.
  - Expect no pushes while either is full.
  - Address, data and mask stay stable; the total request count is unchanged.
- Clipping and degenerate commands:
  - x0=784, x1=1000, y0=y1=700 → no writes; done pulses at T+2.
  - Same with y0=y1=10 → 2 requests with masks all 16'h0000.
  - x0=20, x1=5 → no writes, done pulses at T+2.
- Reset mid-fill: drive rst low for 1 cycle during DATA2 of the third request.
  - Expect no further pushes and ready=1 the cycle after release.
  - A new command then starts cleanly at its own y0.
- Accept while busy: pulse valid with a different rectangle while in ADDR.
  - Expect it ignored; the first command's address sequence is unchanged.
